// File: rtl/cordic_post_adjust.sv
// Output-side quadrant restore for the CORDIC pipeline: pops one fold tag per result
// and moves folded vectoring-mode angles back to their true half-plane.
module cordic_post_adjust #(
  parameter int NUM_DATA    = 3,
  parameter int FUNC_WIDTH  = 1,
  parameter int DATA_WIDTH  = 16,
  parameter int TOTAL_WIDTH = NUM_DATA * DATA_WIDTH + FUNC_WIDTH,
  parameter int TAG_DEPTH   = 16,
  parameter int CNT_WIDTH   = $clog2(TAG_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   t_vld,
  input  logic                   t_fold,
  input  logic                   i_vld,
  input  logic [TOTAL_WIDTH-1:0] i_data,
  input  logic                   i_clr_err,
  output logic                   o_vld,
  output logic [TOTAL_WIDTH-1:0] o_data,
  output logic [CNT_WIDTH-1:0]   o_tag_count,
  output logic                   o_err_ovf,
  output logic                   o_err_udf
);

  localparam int PTR_WIDTH = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam logic [DATA_WIDTH-1:0] ANG_PI = DATA_WIDTH'(25736);

  logic [TAG_DEPTH-1:0]   r_mem;
  logic [PTR_WIDTH-1:0]   r_wptr;
  logic [PTR_WIDTH-1:0]   r_rptr;
  logic [CNT_WIDTH-1:0]   r_count;
  logic                   r_vld;
  logic [TOTAL_WIDTH-1:0] r_data;
  logic                   r_err_ovf;
  logic                   r_err_udf;

  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_ovf;
  logic                   w_udf;
  logic                   w_fold;
  logic                   w_func_vec;
  logic [DATA_WIDTH-1:0]  w_z;
  logic [DATA_WIDTH-1:0]  w_z_adj;
  logic [TOTAL_WIDTH-1:0] w_data_adj;

  assign w_full  = (r_count == CNT_WIDTH'(TAG_DEPTH));
  assign w_empty = (r_count == CNT_WIDTH'(0));
  // A full FIFO still accepts a push when the same cycle pops, since a slot frees up.
  assign w_pop   = i_vld & ~w_empty;
  assign w_push  = t_vld & (~w_full | i_vld);
  assign w_ovf   = t_vld & w_full & ~i_vld;
  assign w_udf   = i_vld & w_empty;

  assign w_func_vec = i_data[TOTAL_WIDTH-1];
  assign w_z        = i_data[DATA_WIDTH-1:0];

  // Fold lookup and angle restore for the sample arriving this cycle
  always_comb begin
    w_fold     = 1'b0;
    w_z_adj    = w_z;
    w_data_adj = i_data;
    if (w_pop) begin
      w_fold = r_mem[r_rptr];
    end else begin
      w_fold = 1'b0;
    end
    if (w_func_vec && w_fold) begin
      if (w_z[DATA_WIDTH-1] || (w_z == DATA_WIDTH'(0))) begin
        w_z_adj = w_z + ANG_PI;
      end else begin
        w_z_adj = w_z - ANG_PI;
      end
    end else begin
      w_z_adj = w_z;
    end
    w_data_adj = {i_data[TOTAL_WIDTH-1:DATA_WIDTH], w_z_adj};
  end

  // Tag FIFO storage, pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= t_fold;
        r_wptr        <= r_wptr + PTR_WIDTH'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_WIDTH'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_WIDTH'(1);
        2'b01:   r_count <= r_count - CNT_WIDTH'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered result and sticky error flags; a new error beats a clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld     <= 1'b0;
      r_data    <= '0;
      r_err_ovf <= 1'b0;
      r_err_udf <= 1'b0;
    end else begin
      r_vld <= i_vld;
      if (i_vld) begin
        r_data <= w_data_adj;
      end
      if (w_ovf) begin
        r_err_ovf <= 1'b1;
      end else if (i_clr_err) begin
        r_err_ovf <= 1'b0;
      end
      if (w_udf) begin
        r_err_udf <= 1'b1;
      end else if (i_clr_err) begin
        r_err_udf <= 1'b0;
      end
    end
  end

  assign o_vld       = r_vld;
  assign o_data      = r_data;
  assign o_tag_count = r_count;
  assign o_err_ovf   = r_err_ovf;
  assign o_err_udf   = r_err_udf;

endmodule
